// File: rtl/vga_timing_generator.sv
// ============================================================================
// vga_timing_generator: VGA raster counters with zero-latency sync/active decode
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_timing_generator #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33
) (
  input  logic       clk25,
  input  logic       reset,
  output logic       screenEnd,
  output logic       active,
  output logic       hSync,
  output logic       vSync,
  output logic [9:0] x,
  output logic [8:0] y
);

  localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] c_h_last     = 10'(H_TOTAL - 1);
  localparam logic [9:0] c_v_last     = 10'(V_TOTAL - 1);
  localparam logic [9:0] c_width      = 10'(WIDTH);
  localparam logic [9:0] c_height     = 10'(HEIGHT);
  localparam logic [9:0] c_hs_start   = 10'(WIDTH + H_FRONT);
  localparam logic [9:0] c_hs_end     = 10'(WIDTH + H_FRONT + H_SYNC);
  localparam logic [9:0] c_vs_start   = 10'(HEIGHT + V_FRONT);
  localparam logic [9:0] c_vs_end     = 10'(HEIGHT + V_FRONT + V_SYNC);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       w_h_wrap;

  always_comb begin
    hcount_d = hcount_q + 10'd1;
    vcount_d = vcount_q;
    w_h_wrap = (hcount_q == c_h_last);
    if (w_h_wrap) begin
      hcount_d = '0;
      vcount_d = (vcount_q == c_v_last) ? '0 : vcount_q + 10'd1;
    end
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  // All decodes use the full 10-bit counters; y alone is ambiguous above line 511.
  assign active    = (hcount_q < c_width) && (vcount_q < c_height);
  assign hSync     = !((hcount_q >= c_hs_start) && (hcount_q < c_hs_end));
  assign vSync     = !((vcount_q >= c_vs_start) && (vcount_q < c_vs_end));
  assign screenEnd = (hcount_q == 10'd0) && (vcount_q == c_height);
  assign x         = hcount_q;
  assign y         = vcount_q[8:0];

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_generator.sv
// ============================================================================
// tb_vga_timing_generator: directed checks on default, narrow-line and tiny instances
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_generator;

  logic clk;
  logic reset;

  logic       d_se, d_act, d_hs, d_vs;
  logic [9:0] d_x;
  logic [8:0] d_y;
  logic       m_se, m_act, m_hs, m_vs;
  logic [9:0] m_x;
  logic [8:0] m_y;
  logic       t_se, t_act, t_hs, t_vs;
  logic [9:0] t_x;
  logic [8:0] t_y;

  int n_tests = 0;
  int n_fail  = 0;

  // Default 640x480 timing
  vga_timing_generator u_dflt (
    .clk25(clk), .reset(reset), .screenEnd(d_se), .active(d_act),
    .hSync(d_hs), .vSync(d_vs), .x(d_x), .y(d_y)
  );

  // 12-pixel lines, default vertical timing: full 525-line frame in 6300 cycles
  vga_timing_generator #(
    .WIDTH(8), .H_FRONT(1), .H_SYNC(1), .H_BACK(2)
  ) u_med (
    .clk25(clk), .reset(reset), .screenEnd(m_se), .active(m_act),
    .hSync(m_hs), .vSync(m_vs), .x(m_x), .y(m_y)
  );

  vga_timing_generator #(
    .WIDTH(8), .HEIGHT(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_tiny (
    .clk25(clk), .reset(reset), .screenEnd(t_se), .active(t_act),
    .hSync(t_hs), .vSync(t_vs), .x(t_x), .y(t_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int d_xerr = 0, d_yerr = 0, d_actn = 0, d_hsn = 0, d_hsfirst = -1;
    int d_hs655 = 0, d_hs752 = 0, d_x800 = -1, d_y800 = -1;
    int m_moderr = 0, m_vsn = 0, m_vsfirst = -1, m_sen = 0, m_se1 = -1, m_se2 = -1;
    int m_sex = -1, m_sey = -1, m_yerr = 0, m_acterr = 0;
    int m_x6299 = -1, m_x6300 = -1, m_y6300 = -1, m_act6300 = -1;
    int t_moderr = 0, t_hsn = 0, t_hsbad = 0, t_vsn = 0, t_sen = 0, t_se1 = -1, t_se2 = -1;
    int c_now;
    int skip;

    reset = 1'b1;
    step(3);
    check_eq("rst_d_x", d_x, 0);
    check_eq("rst_d_y", d_y, 0);
    check_eq("rst_d_act", d_act, 1);
    check_eq("rst_d_hs", d_hs, 1);
    check_eq("rst_d_vs", d_vs, 1);
    check_eq("rst_d_se", d_se, 0);
    check_eq("rst_t_act", t_act, 1);
    check_eq("rst_t_se", t_se, 0);

    reset = 1'b0;
    #1;
    check_eq("rel_d_x", d_x, 0);

    for (int c = 0; c <= 12100; c++) begin
      int mh, mv, th, tv;
      mh = c % 12;
      mv = (c / 12) % 525;
      th = c % 11;
      tv = (c / 11) % 7;

      if (c < 800) begin
        if (d_x != c) d_xerr++;
        if (d_y != 0) d_yerr++;
        if (d_act) d_actn++;
        if (!d_hs) begin
          d_hsn++;
          if (d_hsfirst < 0) d_hsfirst = c;
        end
      end
      if (c == 655) d_hs655 = d_hs;
      if (c == 752) d_hs752 = d_hs;
      if (c == 800) begin
        d_x800 = d_x;
        d_y800 = d_y;
      end

      if (m_x != mh || m_y != (mv % 512) || m_act != (mh < 8 && mv < 480) ||
          m_hs != (mh != 9) || m_vs != !(mv >= 490 && mv < 492))
        m_moderr++;
      if (c < 6300) begin
        if (!m_vs) begin
          m_vsn++;
          if (m_vsfirst < 0) m_vsfirst = c;
        end
        if (m_se) begin
          m_sen++;
          m_se1 = c;
          m_sex = m_x;
          m_sey = m_y;
        end
      end else if (m_se && m_se2 < 0) begin
        m_se2 = c;
      end
      if (c >= 6144 && c < 6300) begin
        if (m_y != mv - 512) m_yerr++;
        if (m_act) m_acterr++;
      end
      if (c == 6299) m_x6299 = m_x;
      if (c == 6300) begin
        m_x6300 = m_x;
        m_y6300 = m_y;
        m_act6300 = m_act;
      end

      if (t_x != th || t_y != tv || t_act != (th < 8 && tv < 4)) t_moderr++;
      if (c < 77) begin
        if (!t_hs) begin
          t_hsn++;
          if (t_x != 9) t_hsbad++;
        end
        if (!t_vs) t_vsn++;
        if (t_se) begin
          t_sen++;
          t_se1 = c;
        end
      end else if (t_se && t_se2 < 0) begin
        t_se2 = c;
      end

      step(1);
    end

    check_eq("d_x_ramp_errs", d_xerr, 0);
    check_eq("d_y_line0_errs", d_yerr, 0);
    check_eq("d_active_cycles", d_actn, 640);
    check_eq("d_hs_low_cycles", d_hsn, 96);
    check_eq("d_hs_first_low_x", d_hsfirst, 656);
    check_eq("d_hs_at_655", d_hs655, 1);
    check_eq("d_hs_at_752", d_hs752, 1);
    check_eq("d_x_after_wrap", d_x800, 0);
    check_eq("d_y_after_wrap", d_y800, 1);

    check_eq("m_model_errs", m_moderr, 0);
    check_eq("m_vs_low_cycles", m_vsn, 24);
    check_eq("m_vs_first_cycle", m_vsfirst, 5880);
    check_eq("m_se_count", m_sen, 1);
    check_eq("m_se_cycle", m_se1, 5760);
    check_eq("m_se_x", m_sex, 0);
    check_eq("m_se_y", m_sey, 480);
    check_eq("m_se_period", m_se2 - m_se1, 6300);
    check_eq("m_y_wrap_errs", m_yerr, 0);
    check_eq("m_blank_active", m_acterr, 0);
    check_eq("m_x_last", m_x6299, 11);
    check_eq("m_x_frame_wrap", m_x6300, 0);
    check_eq("m_y_frame_wrap", m_y6300, 0);
    check_eq("m_act_frame_wrap", m_act6300, 1);

    check_eq("t_model_errs", t_moderr, 0);
    check_eq("t_hs_low_cycles", t_hsn, 7);
    check_eq("t_hs_low_not_x9", t_hsbad, 0);
    check_eq("t_vs_low_cycles", t_vsn, 11);
    check_eq("t_se_count", t_sen, 1);
    check_eq("t_se_cycle", t_se1, 44);
    check_eq("t_se_period", t_se2 - t_se1, 77);

    // Advance the narrow-line instance to line 300, pixel 4, then reset between edges
    c_now = 12101;
    skip = (6300 + 3604 - (c_now % 6300)) % 6300;
    step(skip);
    check_eq("m_pre_rst_x", m_x, 4);
    check_eq("m_pre_rst_y", m_y, 300);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_m_x", m_x, 0);
    check_eq("async_m_y", m_y, 0);
    check_eq("async_m_act", m_act, 1);
    check_eq("async_m_hs", m_hs, 1);
    check_eq("async_m_vs", m_vs, 1);
    check_eq("async_d_x", d_x, 0);
    step(3);
    check_eq("held_m_x", m_x, 0);
    check_eq("held_t_x", t_x, 0);
    reset = 1'b0;
    step(1);
    check_eq("resume_m_x", m_x, 1);
    check_eq("resume_d_x", d_x, 1);
    check_eq("resume_t_x", t_x, 1);
    check_eq("resume_m_y", m_y, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_timing_generator.md
VGA_TIMING_GENERATOR -- requirements
Module: vga_timing_generator

Interface
REQ-001 Parameter WIDTH, default 640, active pixels per line.
REQ-002 Parameter HEIGHT, default 480, active lines per frame.
REQ-003 Parameters H_FRONT 16, H_SYNC 96, H_BACK 48, V_FRONT 10, V_SYNC 2, V_BACK 33 SHALL be the default porch and sync widths, in pixels or lines.
REQ-004 clk25  input  1  pixel clock; the only clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 screenEnd  output  1  one-cycle frame-boundary strobe.
REQ-007 active  output  1  high while the current pixel is in the visible area.
REQ-008 hSync  output  1  horizontal sync, active-low.
REQ-009 vSync  output  1  vertical sync, active-low.
REQ-010 x  output  10  current horizontal count.
REQ-011 y  output  9  current vertical count, low 9 bits.

Function
REQ-012 Internal hCount (10 bits) and vCount (10 bits) SHALL be the only state, both registered on the rising edge of clk25.
REQ-013 H_TOTAL = WIDTH+H_FRONT+H_SYNC+H_BACK (800 by default).
REQ-014 V_TOTAL = HEIGHT+V_FRONT+V_SYNC+V_BACK (525 by default).
REQ-015 hCount SHALL increment by 1 every clk25 cycle and wrap from H_TOTAL-1 to 0.
REQ-016 When hCount wraps, vCount SHALL increment by 1, wrapping from V_TOTAL-1 to 0 in the same cycle that hCount wraps from H_TOTAL-1.
REQ-017 Frame period SHALL be H_TOTAL*V_TOTAL cycles (420000 by default), with no idle cycles between frames.
REQ-018 All outputs SHALL be combinational decodes of the registered counters, so they are valid in the same cycle as the counter value (zero latency).
REQ-019 active = (hCount < WIDTH) AND (vCount < HEIGHT).
REQ-020 hSync SHALL be 0 iff WIDTH+H_FRONT <= hCount < WIDTH+H_FRONT+H_SYNC (656..751 by default); otherwise 1.
REQ-021 vSync SHALL be 0 iff HEIGHT+V_FRONT <= vCount < HEIGHT+V_FRONT+V_SYNC (490..491 by default); otherwise 1.
REQ-022 hSync SHALL be generated on every line, including vertical blanking lines.
REQ-023 screenEnd SHALL be 1 iff hCount == 0 AND vCount == HEIGHT, which is exactly one clk25 cycle per frame, immediately after the last visible line.
REQ-024 x = hCount, covering the full range 0..H_TOTAL-1.
REQ-025 y = vCount[8:0]. During blanking lines at or above 512, y wraps (y = vCount-512); consumers SHALL qualify y with active.
REQ-026 Counter comparisons SHALL use the full 10-bit counters, never the truncated y.

Reset
REQ-027 While reset = 1, hCount and vCount SHALL be held at 0, independent of clk25.
REQ-028 During and immediately after reset, outputs SHALL be x=0, y=0, active=1, hSync=1, vSync=1, screenEnd=0.
REQ-029 Counting SHALL resume on the first rising clk25 edge after reset deasserts, giving x=1 after that edge.
REQ-030 Reset asserted mid-frame SHALL restart the frame at (0,0) with no partial sync pulse completion.

Verification
REQ-031 Release reset and run 800 cycles -> x steps 0..799 then returns to 0; y goes 0->1 on the wrap; active is high for exactly 640 cycles.
REQ-032 Run line 0 -> hSync is low for exactly 96 cycles starting at x=656; hSync is high at x=655 and x=752.
REQ-033 Run one full frame -> vSync is low for exactly 2 lines (1600 cycles) starting at vCount=490; screenEnd pulses once, at vCount=480, x=0; the next screenEnd pulse comes 420000 cycles later.
REQ-034 Observe vCount 512..524 -> y reads 0..12 and active=0 throughout; at vCount 524, x=799, the next edge gives x=0, y=0, active=1.
REQ-035 Assert reset asynchronously at vCount=300, x=400, between clock edges -> outputs immediately show x=0, y=0, active=1, hSync=1, vSync=1; after release, counting restarts from 0.
REQ-036 Instantiate with WIDTH=8, HEIGHT=4 and all porch and sync parameters set to 1 -> H_TOTAL=11, V_TOTAL=7, frame period 77 cycles; hSync is low at x=9 only; screenEnd fires at (0,4).
